// File: rtl/trg_pkg.sv
// -----------------------------------------------------------------------------
// trg_pkg
//   Shared definitions for the trigger/ack sequencer and the Wishbone slave
//   register file: default widths, FSM state type and register offsets.
// -----------------------------------------------------------------------------
package trg_pkg;

   // Default geometry
   localparam int unsigned TRG_NCH    = 12;
   localparam int unsigned TRG_PLEN_W = 16;
   localparam int unsigned TRG_TO_W   = 24;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PULSE    = 2'd1,
      ST_WAIT_ACK = 2'd2,
      ST_FINISH   = 2'd3
   } trg_state_e;

   // Register-field byte offsets shared with WISHBONE_SLAVE
   localparam logic [7:0] REG_CMD_OFS      = 8'h00; // start strobe + channel mask
   localparam logic [7:0] REG_PULSE_LEN_OFS = 8'h04; // pulse length (cycles)
   localparam logic [7:0] REG_TIMEOUT_OFS  = 8'h08; // ack timeout (cycles)
   localparam logic [7:0] REG_STATUS_OFS   = 8'h0C; // busy/done, ack-seen, timed-out
   localparam logic [7:0] REG_ACK_LVL_OFS  = 8'h10; // synchronised ACK level

endpackage

// File: rtl/ack_sync_edge.sv
// -----------------------------------------------------------------------------
// ack_sync_edge
//   Per-channel 2-FF synchroniser for the asynchronous ACK pins followed by a
//   rising-edge detector (one extra flop).
// Ports
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset
//   ack_i    : raw asynchronous ACK pins
//   level_o  : synchronised ACK level
//   edge_o   : one-cycle pulse on a synchronised rising edge
// -----------------------------------------------------------------------------
module ack_sync_edge #(
   parameter int unsigned NCH = 12
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic [NCH-1:0] ack_i,
   output logic [NCH-1:0] level_o,
   output logic [NCH-1:0] edge_o
);

   logic [NCH-1:0] meta_q;
   logic [NCH-1:0] sync_q;
   logic [NCH-1:0] prev_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         meta_q <= ack_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign level_o = sync_q;
   assign edge_o  = sync_q & ~prev_q;

endmodule

// File: rtl/trg_ack_sequencer.sv
// -----------------------------------------------------------------------------
// trg_ack_sequencer
//   Fires a fixed-width trigger pulse on the selected TRG channels on a command
//   strobe, then waits (optionally with timeout) for each selected channel to
//   acknowledge and reports per-channel acked / timed-out status.
// Ports
//   BOARD_CLOCK : clock, rising edge
//   RST         : synchronous active-low reset
//   CMD_START_I : one-cycle start strobe
//   CMD_MASK_I  : channels to fire, sampled on start
//   PULSE_LEN_I : pulse width in cycles (0 treated as 1), sampled on start
//   TIMEOUT_I   : ack timeout in cycles after pulse end (0 = wait forever)
//   ACK_I       : raw asynchronous ACK pins
//   TRG_O       : registered trigger outputs
//   BUSY_O      : sequence in progress
//   DONE_O      : one-cycle completion strobe
//   ACK_SEEN_O  : masked channels that acked in the current/last sequence
//   TIMEOUT_O   : masked channels without ack at timeout
//   ACK_SYNC_O  : synchronised ACK level
// -----------------------------------------------------------------------------
module trg_ack_sequencer
   import trg_pkg::*;
#(
   parameter int unsigned NCH    = TRG_NCH,
   parameter int unsigned PLEN_W = TRG_PLEN_W,
   parameter int unsigned TO_W   = TRG_TO_W
) (
   input  logic              BOARD_CLOCK,
   input  logic              RST,
   input  logic              CMD_START_I,
   input  logic [NCH-1:0]    CMD_MASK_I,
   input  logic [PLEN_W-1:0] PULSE_LEN_I,
   input  logic [TO_W-1:0]   TIMEOUT_I,
   input  logic [NCH-1:0]    ACK_I,
   output logic [NCH-1:0]    TRG_O,
   output logic              BUSY_O,
   output logic              DONE_O,
   output logic [NCH-1:0]    ACK_SEEN_O,
   output logic [NCH-1:0]    TIMEOUT_O,
   output logic [NCH-1:0]    ACK_SYNC_O
);

   trg_state_e        state_q;
   logic [NCH-1:0]    mask_q;
   logic [TO_W-1:0]   to_cfg_q;
   logic [PLEN_W-1:0] pcnt_q;
   logic [TO_W-1:0]   timer_q;
   logic [NCH-1:0]    trg_q;
   logic              busy_q;
   logic              done_q;
   logic [NCH-1:0]    ack_seen_q;
   logic [NCH-1:0]    ack_seen_d;
   logic [NCH-1:0]    timeout_q;
   logic [NCH-1:0]    ack_edge;

   ack_sync_edge #(
      .NCH (NCH)
   ) u_ack_sync (
      .clk_i   (BOARD_CLOCK),
      .rst_ni  (RST),
      .ack_i   (ACK_I),
      .level_o (ACK_SYNC_O),
      .edge_o  (ack_edge)
   );

   // Sticky ack accumulation; only masked channels are recorded
   always_comb begin
      ack_seen_d = ack_seen_q | (ack_edge & mask_q);
   end

   always_ff @(posedge BOARD_CLOCK) begin
      if (!RST) begin
         state_q    <= ST_IDLE;
         mask_q     <= '0;
         to_cfg_q   <= '0;
         pcnt_q     <= '0;
         timer_q    <= '0;
         trg_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ack_seen_q <= '0;
         timeout_q  <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (CMD_START_I) begin
                  busy_q <= 1'b1;
                  if (CMD_MASK_I != '0) begin
                     mask_q     <= CMD_MASK_I;
                     to_cfg_q   <= TIMEOUT_I;
                     pcnt_q     <= (PULSE_LEN_I == '0) ? PLEN_W'(1) : PULSE_LEN_I;
                     trg_q      <= CMD_MASK_I;
                     ack_seen_q <= '0;
                     timeout_q  <= '0;
                     state_q    <= ST_PULSE;
                  end else begin
                     // Empty mask: nothing to fire, complete immediately
                     done_q  <= 1'b1;
                     state_q <= ST_FINISH;
                  end
               end
            end

            ST_PULSE: begin
               ack_seen_q <= ack_seen_d;
               // pcnt_q holds the remaining high cycles including the current one
               if (pcnt_q == PLEN_W'(1)) begin
                  trg_q   <= '0;
                  timer_q <= to_cfg_q;
                  state_q <= ST_WAIT_ACK;
               end else begin
                  pcnt_q <= pcnt_q - PLEN_W'(1);
               end
            end

            ST_WAIT_ACK: begin
               ack_seen_q <= ack_seen_d;
               // Completion is tested before expiry so a simultaneous ack wins
               if ((ack_seen_d & mask_q) == mask_q) begin
                  done_q  <= 1'b1;
                  state_q <= ST_FINISH;
               end else if (to_cfg_q != '0) begin
                  if (timer_q == TO_W'(1)) begin
                     timeout_q <= mask_q & ~ack_seen_d;
                     done_q    <= 1'b1;
                     state_q   <= ST_FINISH;
                  end else begin
                     timer_q <= timer_q - TO_W'(1);
                  end
               end
            end

            ST_FINISH: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign TRG_O      = trg_q;
   assign BUSY_O     = busy_q;
   assign DONE_O     = done_q;
   assign ACK_SEEN_O = ack_seen_q;
   assign TIMEOUT_O  = timeout_q;

endmodule
